// File: rtl/led_frontend_calibrator.sv
// -----------------------------------------------------------------------------
// led_frontend_calibrator
//
// Pulse-oximetry analog front-end controller for NUM_CH LEDs. After a
// find_setting request it calibrates each LED channel in turn:
//   1. DC-compensation DAC search. The DAC moves one code per cycle until the
//      ADC lands within TOL of TARGET.
//   2. PGA gain search. The gain rises one code every GAIN_SETTLE cycles until
//      the ADC clips or the gain saturates.
// When every channel is calibrated, the block runs round-robin LED slots of
// SLOT_CYCLES cycles. In each slot it emits channel-tagged ADC samples and
// drops the first DISCARD settling samples of the slot.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   find_setting_i  level request that starts or restarts calibration
//   adc_i           ADC code
//   led_en_o        one-hot LED enable
//   dc_comp_o       DC-compensation DAC code
//   pga_gain_o      PGA gain code
//   sample_o        registered ADC code
//   sample_ch_o     channel the sample belongs to
//   sample_valid_o  sample qualifier (no back-pressure)
//   cal_done_o      all channels calibrated, high throughout RUN
//   cal_error_o     DAC saturated before convergence, sticky until restart
// -----------------------------------------------------------------------------
module led_frontend_calibrator #(
   parameter int NUM_CH      = 2,
   parameter int ADC_W       = 8,
   parameter int DAC_W       = 7,
   parameter int GAIN_W      = 4,
   parameter int TARGET      = 127,
   parameter int TOL         = 10,
   parameter int CLIP_HI     = 220,
   parameter int CLIP_LO     = 30,
   parameter int GAIN_SETTLE = 1090,
   parameter int SLOT_CYCLES = 20,
   parameter int DISCARD     = 4,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              find_setting_i,
   input  logic [ADC_W-1:0]  adc_i,
   output logic [NUM_CH-1:0] led_en_o,
   output logic [DAC_W-1:0]  dc_comp_o,
   output logic [GAIN_W-1:0] pga_gain_o,
   output logic [ADC_W-1:0]  sample_o,
   output logic [CH_W-1:0]   sample_ch_o,
   output logic              sample_valid_o,
   output logic              cal_done_o,
   output logic              cal_error_o
);

   localparam int TMR_W  = (GAIN_SETTLE > 1) ? $clog2(GAIN_SETTLE) : 1;
   localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   // One extra bit keeps the distance to TARGET and the clip compares unsigned-safe.
   localparam int CMP_W  = ADC_W + 1;

   localparam logic [CMP_W-1:0]  TARGET_C    = CMP_W'(TARGET);
   localparam logic [CMP_W-1:0]  TOL_C       = CMP_W'(TOL);
   localparam logic [CMP_W-1:0]  CLIP_HI_C   = CMP_W'(CLIP_HI);
   localparam logic [CMP_W-1:0]  CLIP_LO_C   = CMP_W'(CLIP_LO);
   localparam logic [TMR_W-1:0]  TMR_LAST_C  = TMR_W'(GAIN_SETTLE - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST_C = SLOT_W'(SLOT_CYCLES - 1);
   localparam logic [SLOT_W-1:0] DISCARD_C   = SLOT_W'(DISCARD);
   localparam logic [CH_W-1:0]   CH_LAST_C   = CH_W'(NUM_CH - 1);
   localparam logic [DAC_W-1:0]  DAC_MAX_C   = {DAC_W{1'b1}};
   localparam logic [GAIN_W-1:0] GAIN_MAX_C  = {GAIN_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_OP_SEARCH   = 3'd1,
      S_GAIN_SEARCH = 3'd2,
      S_NEXT_CH     = 3'd3,
      S_RUN         = 3'd4
   } state_e;

   // One-hot LED enable for a channel index.
   function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] c);
      return NUM_CH'(1) << c;
   endfunction

   // Gain decrement that stops at zero.
   function automatic logic [GAIN_W-1:0] dec_sat0(input logic [GAIN_W-1:0] g);
      if (g == {GAIN_W{1'b0}}) begin
         return {GAIN_W{1'b0}};
      end else begin
         return g - GAIN_W'(1);
      end
   endfunction

   state_e              state_q;
   logic [CH_W-1:0]     ch_q;
   logic [TMR_W-1:0]    timer_q;
   logic [SLOT_W-1:0]   slot_q;
   logic [NUM_CH-1:0]   led_en_q;
   logic [DAC_W-1:0]    dc_comp_q;
   logic [GAIN_W-1:0]   pga_gain_q;
   logic [ADC_W-1:0]    sample_q;
   logic [CH_W-1:0]     sample_ch_q;
   logic                sample_valid_q;
   logic                cal_done_q;
   logic                cal_error_q;
   logic [DAC_W-1:0]    op_q   [NUM_CH];
   logic [GAIN_W-1:0]   gain_q [NUM_CH];

   logic [CMP_W-1:0]    adc_ext_s;
   logic [CMP_W-1:0]    err_mag_s;
   logic                in_tol_s;
   logic                adc_above_s;
   logic                clipped_s;
   logic                ch_last_s;
   logic [CH_W-1:0]     ch_next_d;
   logic [GAIN_W-1:0]   gain_dec_d;

   // Decode ADC position relative to the target window and clip limits.
   always_comb begin
      adc_ext_s = {1'b0, adc_i};
      if (adc_ext_s >= TARGET_C) begin
         err_mag_s = adc_ext_s - TARGET_C;
      end else begin
         err_mag_s = TARGET_C - adc_ext_s;
      end
      in_tol_s    = (err_mag_s <= TOL_C);
      adc_above_s = (adc_ext_s > TARGET_C);
      clipped_s   = (adc_ext_s > CLIP_HI_C) || (adc_ext_s < CLIP_LO_C);
   end

   // Channel wrap and gain back-off values used by the FSM.
   always_comb begin
      ch_last_s = (ch_q == CH_LAST_C);
      if (ch_last_s) begin
         ch_next_d = {CH_W{1'b0}};
      end else begin
         ch_next_d = ch_q + CH_W'(1);
      end
      gain_dec_d = dec_sat0(pga_gain_q);
   end

   // Calibration / run FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         ch_q           <= {CH_W{1'b0}};
         timer_q        <= {TMR_W{1'b0}};
         slot_q         <= {SLOT_W{1'b0}};
         led_en_q       <= {NUM_CH{1'b0}};
         dc_comp_q      <= {DAC_W{1'b0}};
         pga_gain_q     <= {GAIN_W{1'b0}};
         sample_q       <= {ADC_W{1'b0}};
         sample_ch_q    <= {CH_W{1'b0}};
         sample_valid_q <= 1'b0;
         cal_done_q     <= 1'b0;
         cal_error_q    <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            op_q[i]   <= {DAC_W{1'b0}};
            gain_q[i] <= {GAIN_W{1'b0}};
         end
      end else if (find_setting_i) begin
         state_q        <= S_OP_SEARCH;
         ch_q           <= {CH_W{1'b0}};
         led_en_q       <= onehot({CH_W{1'b0}});
         dc_comp_q      <= {DAC_W{1'b0}};
         pga_gain_q     <= {GAIN_W{1'b0}};
         timer_q        <= {TMR_W{1'b0}};
         cal_done_q     <= 1'b0;
         cal_error_q    <= 1'b0;
         sample_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_IDLE;
            end

            S_OP_SEARCH: begin
               if (in_tol_s) begin
                  op_q[ch_q] <= dc_comp_q;
                  timer_q    <= {TMR_W{1'b0}};
                  state_q    <= S_GAIN_SEARCH;
               end else if (adc_above_s) begin
                  // The DAC would step past its top code: abort and keep the code.
                  if (dc_comp_q == DAC_MAX_C) begin
                     cal_error_q <= 1'b1;
                     led_en_q    <= {NUM_CH{1'b0}};
                     state_q     <= S_IDLE;
                  end else begin
                     dc_comp_q <= dc_comp_q + DAC_W'(1);
                  end
               end else begin
                  // The DAC would step below zero: abort and keep the code.
                  if (dc_comp_q == {DAC_W{1'b0}}) begin
                     cal_error_q <= 1'b1;
                     led_en_q    <= {NUM_CH{1'b0}};
                     state_q     <= S_IDLE;
                  end else begin
                     dc_comp_q <= dc_comp_q - DAC_W'(1);
                  end
               end
            end

            S_GAIN_SEARCH: begin
               if (clipped_s) begin
                  // Back off to the last gain code that did not clip.
                  gain_q[ch_q] <= gain_dec_d;
                  pga_gain_q   <= gain_dec_d;
                  state_q      <= S_NEXT_CH;
               end else if (timer_q == TMR_LAST_C) begin
                  timer_q <= {TMR_W{1'b0}};
                  if (pga_gain_q == GAIN_MAX_C) begin
                     gain_q[ch_q] <= GAIN_MAX_C;
                     state_q      <= S_NEXT_CH;
                  end else begin
                     pga_gain_q <= pga_gain_q + GAIN_W'(1);
                  end
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end

            S_NEXT_CH: begin
               if (ch_last_s) begin
                  cal_done_q <= 1'b1;
                  ch_q       <= {CH_W{1'b0}};
                  slot_q     <= {SLOT_W{1'b0}};
                  state_q    <= S_RUN;
               end else begin
                  ch_q       <= ch_next_d;
                  led_en_q   <= onehot(ch_next_d);
                  dc_comp_q  <= {DAC_W{1'b0}};
                  pga_gain_q <= {GAIN_W{1'b0}};
                  state_q    <= S_OP_SEARCH;
               end
            end

            S_RUN: begin
               // The front-end settings for the slot's channel load on its first cycle.
               if (slot_q == {SLOT_W{1'b0}}) begin
                  led_en_q   <= onehot(ch_q);
                  dc_comp_q  <= op_q[ch_q];
                  pga_gain_q <= gain_q[ch_q];
               end else begin
                  led_en_q <= led_en_q;
               end
               sample_q       <= adc_i;
               sample_ch_q    <= ch_q;
               sample_valid_q <= (slot_q >= DISCARD_C);
               if (slot_q == SLOT_LAST_C) begin
                  slot_q <= {SLOT_W{1'b0}};
                  ch_q   <= ch_next_d;
               end else begin
                  slot_q <= slot_q + SLOT_W'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign led_en_o       = led_en_q;
   assign dc_comp_o      = dc_comp_q;
   assign pga_gain_o     = pga_gain_q;
   assign sample_o       = sample_q;
   assign sample_ch_o    = sample_ch_q;
   assign sample_valid_o = sample_valid_q;
   assign cal_done_o     = cal_done_q;
   assign cal_error_o    = cal_error_q;

endmodule

// File: tb/tb_led_frontend_calibrator.sv
// -----------------------------------------------------------------------------
// Directed testbench for led_frontend_calibrator (NUM_CH=2, GAIN_SETTLE=8).
// A small plant model derives adc from the DAC/gain/LED settings so that the
// calibration loop closes. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_led_frontend_calibrator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       find_setting;
   logic [7:0] adc;
   logic [1:0] led_en;
   logic [6:0] dc_comp;
   logic [3:0] pga_gain;
   logic [7:0] sample;
   logic [0:0] sample_ch;
   logic       sample_valid;
   logic       cal_done;
   logic       cal_error;

   int         mode;
   logic [7:0] run_adc;
   int         n_cmp  = 0;
   int         n_fail = 0;
   int         vcnt;
   logic       ch_ok;

   led_frontend_calibrator #(
      .GAIN_SETTLE (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .find_setting_i (find_setting),
      .adc_i          (adc),
      .led_en_o       (led_en),
      .dc_comp_o      (dc_comp),
      .pga_gain_o     (pga_gain),
      .sample_o       (sample),
      .sample_ch_o    (sample_ch),
      .sample_valid_o (sample_valid),
      .cal_done_o     (cal_done),
      .cal_error_o    (cal_error)
   );

   always #5 clk = ~clk;

   // Plant: channel 0 converges at dc=17 and clips at gain 5 (227);
   // channel 1 converges at dc=22 and clips at gain 4 (247).
   always_comb begin
      int base;
      int k;
      int v;
      base = led_en[1] ? 25 : 20;
      k    = led_en[1] ? 30 : 20;
      v    = 127;
      case (mode)
         0: v = 255;
         1: begin
            if (pga_gain == 4'd0) v = 127 + 3 * (base - int'(dc_comp));
            else                  v = 127 + k * int'(pga_gain);
         end
         2: v = int'(run_adc);
         3: v = 0;
         4: v = (dc_comp == 7'd0) ? 138 : 137;
         default: v = 127;
      endcase
      if (v > 255) v = 255;
      if (v < 0)   v = 0;
      adc = v[7:0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n        = 1'b0;
      find_setting = 1'b1;
      mode         = 1;
      run_adc      = 8'd0;

      // T1 reset wins over find_setting
      cyc(2);
      chk("rst_led_en", 32'(led_en), 32'd0);
      chk("rst_dc_comp", 32'(dc_comp), 32'd0);
      chk("rst_pga_gain", 32'(pga_gain), 32'd0);
      chk("rst_sample", 32'(sample), 32'd0);
      chk("rst_sample_ch", 32'(sample_ch), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_cal_done", 32'(cal_done), 32'd0);
      chk("rst_cal_error", 32'(cal_error), 32'd0);
      rst_n = 1'b1;
      cyc(1);
      chk("start_led_en", 32'(led_en), 32'd1);
      chk("start_dc_comp", 32'(dc_comp), 32'd0);
      find_setting = 1'b0;

      // T2 DC operating-point search on channel 0
      cyc(1);
      chk("op0_step1", 32'(dc_comp), 32'd1);
      cyc(16);
      chk("op0_dc17", 32'(dc_comp), 32'd17);
      cyc(1);
      chk("op0_hold", 32'(dc_comp), 32'd17);
      chk("gain0_start", 32'(pga_gain), 32'd0);

      // T3 gain search on channel 0
      cyc(7);
      chk("gain0_settle", 32'(pga_gain), 32'd0);
      cyc(1);
      chk("gain0_step1", 32'(pga_gain), 32'd1);
      cyc(32);
      chk("gain0_step5", 32'(pga_gain), 32'd5);
      cyc(1);
      chk("gain0_clip", 32'(pga_gain), 32'd4);
      cyc(1);
      chk("ch1_led_en", 32'(led_en), 32'd2);
      chk("ch1_dc_clr", 32'(dc_comp), 32'd0);
      chk("ch1_gain_clr", 32'(pga_gain), 32'd0);

      // Channel 1 calibration
      cyc(22);
      chk("op1_dc22", 32'(dc_comp), 32'd22);
      cyc(33);
      chk("gain1_step4", 32'(pga_gain), 32'd4);
      cyc(1);
      chk("gain1_clip", 32'(pga_gain), 32'd3);
      chk("cal_done_lo", 32'(cal_done), 32'd0);
      cyc(1);
      chk("cal_done_hi", 32'(cal_done), 32'd1);
      mode    = 2;
      run_adc = 8'h5A;

      // T5 RUN: slot for channel 0
      cyc(1);
      chk("run0_led_en", 32'(led_en), 32'd1);
      chk("run0_dc", 32'(dc_comp), 32'd17);
      chk("run0_gain", 32'(pga_gain), 32'd4);
      chk("run0_sample", 32'(sample), 32'h5A);
      chk("run0_valid0", 32'(sample_valid), 32'd0);
      vcnt  = 0;
      ch_ok = (sample_ch == 1'b0);
      for (int i = 1; i < 20; i++) begin
         cyc(1);
         if (sample_valid) vcnt++;
         if (sample_ch != 1'b0) ch_ok = 1'b0;
      end
      chk("run0_nvalid", 32'(vcnt), 32'd16);
      chk("run0_ch_tag", 32'(ch_ok), 32'd1);
      run_adc = 8'hC3;

      // Slot for channel 1
      cyc(1);
      chk("run1_led_en", 32'(led_en), 32'd2);
      chk("run1_dc", 32'(dc_comp), 32'd22);
      chk("run1_gain", 32'(pga_gain), 32'd3);
      chk("run1_sample", 32'(sample), 32'hC3);
      chk("run1_ch", 32'(sample_ch), 32'd1);
      chk("run1_valid0", 32'(sample_valid), 32'd0);
      vcnt  = 0;
      ch_ok = 1'b1;
      for (int i = 1; i < 20; i++) begin
         cyc(1);
         if (sample_valid) vcnt++;
         if (sample_ch != 1'b1) ch_ok = 1'b0;
      end
      chk("run1_nvalid", 32'(vcnt), 32'd16);
      chk("run1_ch_tag", 32'(ch_ok), 32'd1);
      cyc(1);
      chk("run2_led_en", 32'(led_en), 32'd1);
      chk("run2_ch", 32'(sample_ch), 32'd0);
      chk("run2_cal_done", 32'(cal_done), 32'd1);

      // T6 recalibrate mid-RUN
      find_setting = 1'b1;
      cyc(1);
      chk("recal_done", 32'(cal_done), 32'd0);
      chk("recal_valid", 32'(sample_valid), 32'd0);
      chk("recal_led_en", 32'(led_en), 32'd1);
      chk("recal_dc", 32'(dc_comp), 32'd0);
      find_setting = 1'b0;
      mode         = 1;
      cyc(1);
      chk("recal_op_step", 32'(dc_comp), 32'd1);

      // T4 upper DAC saturation
      mode         = 0;
      find_setting = 1'b1;
      cyc(1);
      chk("sat_dc0", 32'(dc_comp), 32'd0);
      find_setting = 1'b0;
      cyc(127);
      chk("sat_dc127", 32'(dc_comp), 32'd127);
      chk("sat_err_lo", 32'(cal_error), 32'd0);
      cyc(1);
      chk("sat_err_hi", 32'(cal_error), 32'd1);
      chk("sat_led_off", 32'(led_en), 32'd0);
      chk("sat_dc_hold", 32'(dc_comp), 32'd127);
      cyc(3);
      chk("sat_idle_dc", 32'(dc_comp), 32'd127);
      chk("sat_sticky", 32'(cal_error), 32'd1);

      // Lower DAC saturation: below target with DAC already at zero
      mode         = 3;
      find_setting = 1'b1;
      cyc(1);
      chk("low_err_clr", 32'(cal_error), 32'd0);
      find_setting = 1'b0;
      cyc(1);
      chk("low_err_hi", 32'(cal_error), 32'd1);
      chk("low_led_off", 32'(led_en), 32'd0);
      chk("low_dc_hold", 32'(dc_comp), 32'd0);

      // Tolerance edge: 138 steps the DAC, 137 is accepted
      mode         = 4;
      find_setting = 1'b1;
      cyc(1);
      find_setting = 1'b0;
      cyc(1);
      chk("tol_138_step", 32'(dc_comp), 32'd1);
      cyc(2);
      chk("tol_137_accept", 32'(dc_comp), 32'd1);
      chk("tol_gain_zero", 32'(pga_gain), 32'd0);
      chk("tol_no_error", 32'(cal_error), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
